// File: rtl/add4_pkg.sv
// add4_pkg: shared defaults and result-width helper for the four-operand adder
package add4_pkg;
    localparam int DEF_W  = 16;
    localparam int DEF_TW = 4;

    function automatic int calc_ow(input int w);
        return w + 2;
    endfunction
endpackage

// File: rtl/compressor_row_4to2.sv
// compressor_row_4to2: one row of 4:2 compressor cells reducing four operands to sum/carry vectors
module compressor_row_4to2 #(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    input  logic [W-1:0] d,
    output logic [W:0]   sum,
    output logic [W:0]   carry
);
    logic [W:0]   cy;
    logic [W-1:0] s1;

    assign cy[0] = 1'b0;

    for (genvar i = 0; i < W; i++) begin : g_cell
        assign s1[i]    = a[i] ^ b[i] ^ c[i];
        assign cy[i+1]  = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
        assign sum[i]   = s1[i] ^ d[i] ^ cy[i];
        assign carry[i] = (s1[i] & d[i]) | (s1[i] & cy[i]) | (d[i] & cy[i]);
    end

    // the last cell's internal carry-out has weight 2^W, so it lands in the top sum bit
    assign sum[W]   = cy[W];
    assign carry[W] = 1'b0;
endmodule

// File: rtl/add4_pipe.sv
// add4_pipe: two-stage valid/ready pipeline summing four unsigned operands with a sideband tag
module add4_pipe
    import add4_pkg::*;
#(
    parameter int  W  = DEF_W,
    parameter int  TW = DEF_TW,
    localparam int OW = calc_ow(W)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_a,
    input  logic [W-1:0]  in_b,
    input  logic [W-1:0]  in_c,
    input  logic [W-1:0]  in_d,
    input  logic [TW-1:0] in_tag,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [OW-1:0] out_sum,
    output logic [TW-1:0] out_tag
);
    logic [W:0]    row_sum;
    logic [W:0]    row_carry;
    logic [W:0]    s1_sum;
    logic [W:0]    s1_carry;
    logic [TW-1:0] s1_tag;
    logic          s1_valid;
    logic          s1_load;
    logic          s2_load;

    compressor_row_4to2 #(.W(W)) u_row (
        .a     (in_a),
        .b     (in_b),
        .c     (in_c),
        .d     (in_d),
        .sum   (row_sum),
        .carry (row_carry)
    );

    assign s2_load  = !out_valid || out_ready;
    assign s1_load  = !s1_valid || s2_load;
    assign in_ready = s1_load;

    // stage 1: capture redundant sum/carry vectors only on an input transfer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_sum   <= '0;
            s1_carry <= '0;
            s1_tag   <= '0;
        end else if (s1_load) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_sum   <= row_sum;
                s1_carry <= row_carry;
                s1_tag   <= in_tag;
            end
        end
    end

    // stage 2: carry-propagate add of the redundant pair into the full-width result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_tag   <= '0;
        end else if (s2_load) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_sum <= OW'(s1_sum) + {s1_carry, 1'b0};
                out_tag <= s1_tag;
            end
        end
    end
endmodule

// File: tb/tb_add4_pipe.sv
// tb_add4_pipe: directed vectors, latency/backpressure/reset sequences and a scoreboard for add4_pipe
module tb_add4_pipe;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_a = '0, in_b = '0, in_c = '0, in_d = '0;
    logic [3:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [17:0] out_sum;
    logic [3:0]  out_tag;

    int checks = 0;
    int failures = 0;
    int in_cnt = 0;
    int out_cnt = 0;

    logic [21:0] q[$];
    logic        held_v = 1'b0;
    logic [21:0] held;

    typedef struct {
        logic [15:0] a, b, c, d;
        logic [3:0]  tag;
        logic [17:0] sum;
    } vec_t;

    vec_t tbl[9];

    add4_pipe #(.W(16), .TW(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_c      (in_c),
        .in_d      (in_d),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_tag   (out_tag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] a, b, c, d, input logic [3:0] tag);
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        in_c = c;
        in_d = d;
        in_tag = tag;
    endtask

    task automatic drain(input string name);
        int n;
        in_valid = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while ((q.size() != 0 || out_valid) && n < 200) begin
            step();
            n++;
        end
        chk({name, " drained"}, 64'(q.size()), 64'd0);
        chk({name, " in/out count"}, 64'(out_cnt), 64'(in_cnt));
    endtask

    // scoreboard: sample both handshakes mid-cycle, away from the active edge
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            held_v = 1'b0;
        end else begin
            if (held_v && out_valid)
                chk("hold stable", 64'({out_tag, out_sum}), 64'(held));
            held_v = out_valid && !out_ready;
            held = {out_tag, out_sum};
            if (out_valid && out_ready) begin
                out_cnt++;
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb spurious: got %0h expected none at %0t", {out_tag, out_sum}, $time);
                end else begin
                    chk("sb result", 64'({out_tag, out_sum}), 64'(q.pop_front()));
                end
            end
            if (in_valid && in_ready) begin
                in_cnt++;
                q.push_back({in_tag, 18'(in_a) + 18'(in_b) + 18'(in_c) + 18'(in_d)});
            end
        end
    end

    initial begin
        int sent;
        int cyc;
        logic acc;

        tbl[0] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 4'h5, 18'h3FFFC};
        tbl[1] = '{16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 4'h1, 18'h10000};
        tbl[2] = '{16'h8000, 16'h8000, 16'h8000, 16'h8000, 4'h2, 18'h20000};
        tbl[3] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 4'h3, 18'h00000};
        tbl[4] = '{16'h0001, 16'h0002, 16'h0003, 16'h0004, 4'h4, 18'h0000A};
        tbl[5] = '{16'h1234, 16'h1111, 16'h2222, 16'h0001, 4'h6, 18'h04568};
        tbl[6] = '{16'hAAAA, 16'h5555, 16'hAAAA, 16'h5555, 4'hA, 18'h1FFFE};
        tbl[7] = '{16'h7FFF, 16'h0001, 16'h7FFF, 16'h0001, 4'hF, 18'h10000};
        tbl[8] = '{16'hFFFF, 16'h0000, 16'h0000, 16'h0001, 4'h0, 18'h10000};

        #2 rst_n = 1'b0;
        #1;
        chk("reset out_valid", 64'(out_valid), 64'd0);
        chk("reset out_sum", 64'(out_sum), 64'd0);
        chk("reset out_tag", 64'(out_tag), 64'd0);
        chk("reset in_ready", 64'(in_ready), 64'd1);
        step();
        step();
        rst_n = 1'b1;
        chk("post-reset in_ready", 64'(in_ready), 64'd1);
        step();

        for (int i = 0; i < 9; i++) begin
            chk("vec in_ready", 64'(in_ready), 64'd1);
            drive(tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].d, tbl[i].tag);
            step();
            in_valid = 1'b0;
            chk("vec lat cycle1 out_valid", 64'(out_valid), 64'd0);
            step();
            chk("vec lat cycle2 out_valid", 64'(out_valid), 64'd1);
            chk($sformatf("vec%0d out_sum", i), 64'(out_sum), 64'(tbl[i].sum));
            chk($sformatf("vec%0d out_tag", i), 64'(out_tag), 64'(tbl[i].tag));
            step();
        end
        drain("vectors");

        for (int i = 0; i < 102; i++) begin
            if (i < 100) begin
                chk("burst in_ready", 64'(in_ready), 64'd1);
                drive(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 4'($urandom));
            end else begin
                in_valid = 1'b0;
            end
            if (i >= 2)
                chk("burst out_valid", 64'(out_valid), 64'd1);
            step();
        end
        drain("burst");

        out_ready = 1'b0;
        drive(16'h0001, 16'h0002, 16'h0003, 16'h0004, 4'h1);
        step();
        drive(16'h1000, 16'h1000, 16'h1000, 16'h1000, 4'h2);
        step();
        drive(16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000, 4'h3);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp in_ready", 64'(in_ready), 64'd0);
            chk("bp out_valid", 64'(out_valid), 64'd1);
            chk("bp out_sum", 64'(out_sum), 64'h0000A);
            chk("bp out_tag", 64'(out_tag), 64'h1);
            step();
        end
        out_ready = 1'b1;
        #1;
        chk("release in_ready", 64'(in_ready), 64'd1);
        step();
        in_valid = 1'b0;
        chk("release out_sum", 64'(out_sum), 64'h04000);
        chk("release out_tag", 64'(out_tag), 64'h2);
        chk("release full", 64'(dut.s1_valid), 64'd1);
        step();
        chk("release third sum", 64'(out_sum), 64'h1FFFE);
        drain("backpressure");

        sent = 0;
        cyc = 0;
        while (sent < 1000 && cyc < 20000) begin
            out_ready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1)
                drive(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 4'($urandom));
            else
                in_valid = 1'b0;
            #1;
            acc = in_valid && in_ready;
            step();
            if (acc)
                sent++;
            cyc++;
        end
        chk("random sets sent", 64'(sent), 64'd1000);
        drain("random");

        out_ready = 1'b0;
        drive(16'h0011, 16'h0022, 16'h0033, 16'h0044, 4'h7);
        step();
        drive(16'h0100, 16'h0200, 16'h0300, 16'h0400, 4'h8);
        step();
        in_valid = 1'b0;
        chk("inflight out_valid", 64'(out_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("midreset out_valid", 64'(out_valid), 64'd0);
        chk("midreset out_sum", 64'(out_sum), 64'd0);
        chk("midreset s1_valid", 64'(dut.s1_valid), 64'd0);
        chk("midreset in_ready", 64'(in_ready), 64'd1);
        step();
        step();
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("after reset out_valid", 64'(out_valid), 64'd0);
            chk("after reset out_sum", 64'(out_sum), 64'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
